spi_word_master: RTL and testbench
==================================

# spi_word_master

Parametrised SPI write/readback master for the board's serially configured clock and converter devices (CDCE and successors). It takes a word of up to WORD_W bits plus a chip-select index, emits it MSB-first in SPI mode 0 with a programmable SCLK rate, and captures MISO into a readback word. A guaranteed CS-high gap separates back-to-back transactions. It sits between the configuration sequencer (ROM/FSM that issues register writes) and the device pins.

## Interface
- WORD_W, 32, bits per transaction (≥2)
- NUM_CS, 1, number of chip-select outputs (≥1)
- CLK_DIV, 2, clk cycles per SCLK half-period (≥1)
- GAP_CYCLES, 1, minimum clk cycles with all cs_n high between transactions (≥1)
- CS_W, $clog2(NUM_CS) min 1, width of cs_sel (derived)

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  gates acceptance of new starts only
- start  in  1  request; accepted when enable=1 and busy=0
- cs_sel  in  CS_W  target chip-select index, captured at accept
- tx_word  in  WORD_W  data to send, captured at accept
- miso  in  1  serial data from device
- sclk  out  1  serial clock, idles low
- cs_n  out  NUM_CS  active-low selects
- mosi  out  1  serial data to device
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- rx_word  out  WORD_W  captured MISO bits, valid with done, held until next done
- rx_valid  out  1  equals done

## Operation
- States: IDLE, SETUP, SHIFT, GAP.
- IDLE: start & enable & ~busy → capture tx_word, cs_sel; next cycle enter SETUP. start without enable ignored.
- SETUP (CLK_DIV cycles): selected cs_n[cs_sel] low, mosi = tx_word[WORD_W-1], sclk low.
- SHIFT (2·CLK_DIV·WORD_W cycles): per bit, sclk high CLK_DIV cycles then low CLK_DIV cycles. MISO sampled into rx shift register on the clk edge where sclk rises. mosi advances to next bit on the cycle sclk falls; after the last bit mosi holds the LSB.
- GAP (GAP_CYCLES cycles): all cs_n high, sclk low, mosi 0.
- After GAP: return to IDLE; done=rx_valid=1 for that one cycle; rx_word updated same cycle.
- cs_sel ≥ NUM_CS: transaction runs with no cs_n asserted; done still pulses.
- enable deasserted mid-transaction: transaction completes normally.
- start while busy: ignored, not queued.

## Timing
- Reset values: sclk 0, cs_n all 1, mosi 0, busy 0, done 0, rx_valid 0, rx_word 0, state IDLE. Reset mid-transaction aborts immediately to these values.
- Accept at cycle 0 → busy=1 and cs_n low from cycle 1; cs_n low for exactly CLK_DIV·(2·WORD_W+1) cycles.
- done at cycle 1 + CLK_DIV·(2·WORD_W+1) + GAP_CYCLES; busy low in the done cycle; a start in the done cycle is accepted.
- Defaults: cs_n low cycles 1–130, GAP cycle 131, done cycle 132.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Package spi_word_pkg: state enum, parameter legality checks.
- Sub-module spi_half_period_timer: CLK_DIV down-counter producing a half-period tick; bit counter of width $clog2(WORD_W)+1 stays in top level.
- Single tx/rx shift register pair; no vendor shift-register primitives.

## Test plan
- Defaults, tx_word=0xA5A5_0F0F, miso looped from mosi → mosi bit sequence matches MSB-first, rx_word=0xA5A5_0F0F, done at cycle 132.
- WORD_W=24, CLK_DIV=3, NUM_CS=4, cs_sel=2 → only cs_n[2] low for 147 cycles, sclk period 6 cycles, 24 rising edges.
- Hold start high continuously, GAP_CYCLES=3 → every pair of transactions separated by ≥3 cycles of all cs_n high; one done per transaction.
- enable=0 with start=1 → no activity; drop enable mid-transaction → transaction completes, done pulses.
- reset_n low at bit 10 of a transaction → all outputs to reset values same cycle; after release, a new start completes correctly.
- NUM_CS=2, cs_sel=3 → cs_n stays 2'b11, sclk still toggles 2·WORD_W times, done pulses.

Source files
------------

// File: rtl/spi_word_pkg.sv
// Shared types and elaboration-time parameter checks for the SPI word master.
package spi_word_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      GAP   = 2'd3
   } state_t;

   function automatic bit params_ok(input int word_w, input int num_cs, input int clk_div,
                                    input int gap_cycles, input int cs_w);
      return (word_w >= 2) && (num_cs >= 1) && (clk_div >= 1) && (gap_cycles >= 1)
             && (cs_w >= 1) && ((64'd1 << cs_w) >= 64'(num_cs));
   endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// Free-running CLK_DIV down-counter; tick marks the last clk of each SCLK half-period.
module spi_half_period_timer #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic run,
   output logic tick
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_reg <= RELOAD;
      end else if (!run || (cnt_reg == '0)) begin
         cnt_reg <= RELOAD;
      end else begin
         cnt_reg <= cnt_reg - CNT_W'(1);
      end
   end

   assign tick = run && (cnt_reg == '0);

endmodule

// File: rtl/spi_word_master.sv
// SPI mode-0 word master: MSB-first write with simultaneous MISO readback and a CS-high gap.
module spi_word_master
   import spi_word_pkg::*;
#(
   parameter int WORD_W     = 32,
   parameter int NUM_CS     = 1,
   parameter int CLK_DIV    = 2,
   parameter int GAP_CYCLES = 1,
   parameter int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              start,
   input  logic [CS_W-1:0]   cs_sel,
   input  logic [WORD_W-1:0] tx_word,
   input  logic              miso,
   output logic              sclk,
   output logic [NUM_CS-1:0] cs_n,
   output logic              mosi,
   output logic              busy,
   output logic              done,
   output logic [WORD_W-1:0] rx_word,
   output logic              rx_valid
);

   localparam int BIT_W = $clog2(WORD_W) + 1;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   if (!params_ok(WORD_W, NUM_CS, CLK_DIV, GAP_CYCLES, CS_W)) begin : g_param_check
      $error("spi_word_master: illegal parameter combination");
   end

   state_t            state_reg, state_next;
   logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
   logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
   logic [CS_W-1:0]   cs_idx_reg, cs_idx_next;
   logic [WORD_W-1:0] tx_sr_reg, tx_sr_next;
   logic [WORD_W-1:0] rx_sr_reg, rx_sr_next;
   logic [WORD_W-1:0] rx_word_reg, rx_word_next;
   logic [NUM_CS-1:0] cs_n_reg, cs_n_next;
   logic              sclk_reg, sclk_next;
   logic              done_reg, done_next;
   logic              busy_reg;
   logic              tick, last_bit, cs_window_next;

   spi_half_period_timer #(.CLK_DIV(CLK_DIV)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .run     ((state_reg == SETUP) || (state_reg == SHIFT)),
      .tick    (tick)
   );

   assign last_bit = (bit_cnt_reg == BIT_W'(WORD_W - 1));

   always_comb begin
      state_next   = state_reg;
      bit_cnt_next = bit_cnt_reg;
      gap_cnt_next = gap_cnt_reg;
      cs_idx_next  = cs_idx_reg;
      tx_sr_next   = tx_sr_reg;
      rx_sr_next   = rx_sr_reg;
      rx_word_next = rx_word_reg;
      sclk_next    = sclk_reg;
      done_next    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start && enable) begin
               state_next   = SETUP;
               tx_sr_next   = tx_word;
               cs_idx_next  = cs_sel;
               bit_cnt_next = '0;
            end
         end
         SETUP: begin
            if (tick) begin
               state_next = SHIFT;
               sclk_next  = 1'b1;
               rx_sr_next = {rx_sr_reg[WORD_W-2:0], miso};
            end
         end
         SHIFT: begin
            if (tick) begin
               if (sclk_reg) begin
                  // Falling edge: present the next bit, but keep the LSB after the final bit.
                  sclk_next = 1'b0;
                  if (!last_bit) begin
                     tx_sr_next = {tx_sr_reg[WORD_W-2:0], 1'b0};
                  end
               end else if (last_bit) begin
                  state_next   = GAP;
                  tx_sr_next   = '0;
                  gap_cnt_next = GAP_W'(GAP_CYCLES - 1);
               end else begin
                  sclk_next    = 1'b1;
                  bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                  rx_sr_next   = {rx_sr_reg[WORD_W-2:0], miso};
               end
            end
         end
         GAP: begin
            if (gap_cnt_reg == '0) begin
               state_next   = IDLE;
               done_next    = 1'b1;
               rx_word_next = rx_sr_reg;
            end else begin
               gap_cnt_next = gap_cnt_reg - GAP_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Decode from next-state values so the selects are registered yet aligned with the state.
   assign cs_window_next = (state_next == SETUP) || (state_next == SHIFT);

   for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs
      assign cs_n_next[gi] = !(cs_window_next && (cs_idx_next == CS_W'(gi)));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= IDLE;
         bit_cnt_reg <= '0;
         gap_cnt_reg <= '0;
         cs_idx_reg  <= '0;
         tx_sr_reg   <= '0;
         rx_sr_reg   <= '0;
         rx_word_reg <= '0;
         cs_n_reg    <= '1;
         sclk_reg    <= 1'b0;
         done_reg    <= 1'b0;
         busy_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         bit_cnt_reg <= bit_cnt_next;
         gap_cnt_reg <= gap_cnt_next;
         cs_idx_reg  <= cs_idx_next;
         tx_sr_reg   <= tx_sr_next;
         rx_sr_reg   <= rx_sr_next;
         rx_word_reg <= rx_word_next;
         cs_n_reg    <= cs_n_next;
         sclk_reg    <= sclk_next;
         done_reg    <= done_next;
         busy_reg    <= (state_next != IDLE);
      end
   end

   assign sclk     = sclk_reg;
   assign cs_n     = cs_n_reg;
   assign mosi     = tx_sr_reg[WORD_W-1];
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign rx_valid = done_reg;
   assign rx_word  = rx_word_reg;

endmodule

// File: tb/tb_spi_word_master.sv
// Directed bench for spi_word_master: default, 4-CS/24-bit and out-of-range-select instances.
`timescale 1ns/1ps
module tb_spi_word_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end else begin
         $display("ok   %s value=%0h", name, act);
      end
   endtask

   // Instance A: all defaults, MISO either looped from MOSI or tied to a constant.
   logic        rst_a_n = 1'b1, en_a = 1'b0, start_a = 1'b0, loop_a = 1'b1, mc_a = 1'b0;
   logic [0:0]  cs_sel_a = '0;
   logic [31:0] tx_a = '0, rx_a;
   logic        miso_a, sclk_a, mosi_a, busy_a, done_a, rxv_a;
   logic [0:0]  cs_n_a;
   assign miso_a = loop_a ? mosi_a : mc_a;

   spi_word_master dut_a (
      .clk(clk), .reset_n(rst_a_n), .enable(en_a), .start(start_a), .cs_sel(cs_sel_a),
      .tx_word(tx_a), .miso(miso_a), .sclk(sclk_a), .cs_n(cs_n_a), .mosi(mosi_a),
      .busy(busy_a), .done(done_a), .rx_word(rx_a), .rx_valid(rxv_a)
   );

   // Instance B: 24-bit words, 4 selects, slower SCLK, longer gap; MISO looped.
   logic        rst_bc_n = 1'b1, en_b = 1'b0, start_b = 1'b0;
   logic [1:0]  cs_sel_b = '0;
   logic [23:0] tx_b = '0, rx_b;
   logic        sclk_b, mosi_b, busy_b, done_b, rxv_b;
   logic [3:0]  cs_n_b;

   spi_word_master #(.WORD_W(24), .NUM_CS(4), .CLK_DIV(3), .GAP_CYCLES(3)) dut_b (
      .clk(clk), .reset_n(rst_bc_n), .enable(en_b), .start(start_b), .cs_sel(cs_sel_b),
      .tx_word(tx_b), .miso(mosi_b), .sclk(sclk_b), .cs_n(cs_n_b), .mosi(mosi_b),
      .busy(busy_b), .done(done_b), .rx_word(rx_b), .rx_valid(rxv_b)
   );

   // Instance C: two selects addressed by a 2-bit index so index 3 is out of range.
   logic        en_c = 1'b0, start_c = 1'b0;
   logic [1:0]  cs_sel_c = '0;
   logic [7:0]  tx_c = '0, rx_c;
   logic        sclk_c, mosi_c, busy_c, done_c, rxv_c;
   logic [1:0]  cs_n_c;

   spi_word_master #(.WORD_W(8), .NUM_CS(2), .CLK_DIV(1), .GAP_CYCLES(1), .CS_W(2)) dut_c (
      .clk(clk), .reset_n(rst_bc_n), .enable(en_c), .start(start_c), .cs_sel(cs_sel_c),
      .tx_word(tx_c), .miso(mosi_c), .sclk(sclk_c), .cs_n(cs_n_c), .mosi(mosi_c),
      .busy(busy_c), .done(done_c), .rx_word(rx_c), .rx_valid(rxv_c)
   );

   typedef struct {
      logic [31:0] tx;
      bit          loop;
      bit          mc;
      bit          drop_en;
      logic [31:0] exp_rx;
   } vec_t;

   vec_t vecs[6];

   // One transaction on A; cycle 1 is the first clk after the accepting edge.
   task automatic run_a(input logic [31:0] tx, input bit drop_en, output logic [31:0] mosi_w,
                        output int cs_low, output int rises, output int done_cyc, output int busy1);
      logic prev_sclk;
      @(negedge clk);
      tx_a = tx; start_a = 1'b1; en_a = 1'b1;
      @(posedge clk);
      mosi_w = '0; cs_low = 0; rises = 0; done_cyc = 0; busy1 = 0; prev_sclk = 1'b0;
      for (int c = 1; c <= 300 && done_cyc == 0; c++) begin
         @(negedge clk);
         if (c == 1) begin
            start_a = 1'b0;
            busy1 = int'(busy_a);
         end
         if (drop_en && c == 5) en_a = 1'b0;
         if (cs_n_a[0] == 1'b0) cs_low++;
         if (sclk_a && !prev_sclk) begin
            rises++;
            mosi_w = {mosi_w[30:0], mosi_a};
         end
         prev_sclk = sclk_a;
         if (done_a) done_cyc = c;
      end
      en_a = 1'b1;
   endtask

   task automatic run_c(input logic [1:0] sel, input logic [7:0] tx, output int any_low,
                        output int lo0, output int toggles, output int done_cyc);
      logic prev_sclk;
      @(negedge clk);
      cs_sel_c = sel; tx_c = tx; start_c = 1'b1; en_c = 1'b1;
      @(posedge clk);
      any_low = 0; lo0 = 0; toggles = 0; done_cyc = 0; prev_sclk = 1'b0;
      for (int c = 1; c <= 100 && done_cyc == 0; c++) begin
         @(negedge clk);
         start_c = 1'b0;
         if (cs_n_c != 2'b11) any_low++;
         if (cs_n_c == 2'b10) lo0++;
         if (sclk_c != prev_sclk) toggles++;
         prev_sclk = sclk_c;
         if (done_c) done_cyc = c;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] mw;
      int cs_low, rises, done_cyc, busy1, any_low, lo0, toggles;
      int only2, other, high_cnt, r1, r2, ndone, nper, min_gap, run_hi, last_done;
      logic prev;
      bit in_low, seen_low, activity;

      vecs[0] = '{32'hA5A5_0F0F, 1'b1, 1'b0, 1'b0, 32'hA5A5_0F0F};
      vecs[1] = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF};
      vecs[2] = '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
      vecs[3] = '{32'h8000_0001, 1'b1, 1'b0, 1'b0, 32'h8000_0001};
      vecs[4] = '{32'h1234_5678, 1'b1, 1'b0, 1'b1, 32'h1234_5678};
      vecs[5] = '{32'h0F0F_00FF, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF};

      #2;
      rst_a_n = 1'b0; rst_bc_n = 1'b0;
      #1;
      check("a_reset_outs", {sclk_a, cs_n_a, mosi_a, busy_a, done_a, rxv_a}, 6'b010000);
      check("a_reset_rx", rx_a, 32'h0);
      check("b_reset_outs", {sclk_b, cs_n_b, busy_b, done_b}, 7'b0_1111_00);
      check("c_reset_outs", {sclk_c, cs_n_c, busy_c, done_c}, 5'b0_11_00);
      repeat (3) @(negedge clk);
      rst_a_n = 1'b1; rst_bc_n = 1'b1;
      repeat (2) @(negedge clk);
      check("a_idle_after_reset", {sclk_a, cs_n_a, mosi_a, busy_a}, 4'b0100);

      // Table-driven transactions on A.
      for (int i = 0; i < 6; i++) begin
         loop_a = vecs[i].loop; mc_a = vecs[i].mc;
         run_a(vecs[i].tx, vecs[i].drop_en, mw, cs_low, rises, done_cyc, busy1);
         $display("vec %0d tx=%08h rx=%08h done_cyc=%0d", i, vecs[i].tx, rx_a, done_cyc);
         check($sformatf("v%0d_done_cycle", i), done_cyc, 132);
         check($sformatf("v%0d_rx_word", i), rx_a, vecs[i].exp_rx);
         check($sformatf("v%0d_rx_valid", i), rxv_a, 1'b1);
         check($sformatf("v%0d_busy_done_cyc", i), busy_a, 1'b0);
         check($sformatf("v%0d_busy_cyc1", i), busy1, 1);
         check($sformatf("v%0d_mosi_bits", i), mw, vecs[i].tx);
         check($sformatf("v%0d_cs_low", i), cs_low, 130);
         check($sformatf("v%0d_sclk_rises", i), rises, 32);
         @(negedge clk);
         check($sformatf("v%0d_done_pulse", i), {done_a, rxv_a}, 2'b00);
         check($sformatf("v%0d_rx_held", i), rx_a, vecs[i].exp_rx);
      end

      // start without enable must do nothing.
      loop_a = 1'b1;
      @(negedge clk);
      en_a = 1'b0; start_a = 1'b1; tx_a = 32'hDEAD_BEEF; activity = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (busy_a || sclk_a || !cs_n_a[0] || done_a) activity = 1'b1;
      end
      check("a_enable_low_idle", activity, 1'b0);
      start_a = 1'b0; en_a = 1'b1;

      // Reset during bit 10 aborts to reset values at once; a new transaction then works.
      @(negedge clk);
      tx_a = 32'hFFFF_FFFF; start_a = 1'b1;
      @(posedge clk);
      rises = 0; prev = 1'b0;
      for (int c = 0; c < 300 && rises < 11; c++) begin
         @(negedge clk);
         start_a = 1'b0;
         if (sclk_a && !prev) rises++;
         prev = sclk_a;
      end
      check("a_rst_mid_reached_bit10", rises, 11);
      check("a_rst_mid_active", {sclk_a, cs_n_a, mosi_a, busy_a}, 4'b1011);
      rst_a_n = 1'b0;
      #1;
      check("a_rst_mid_outs", {sclk_a, cs_n_a, mosi_a, busy_a, done_a, rxv_a}, 6'b010000);
      check("a_rst_mid_rx", rx_a, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_a_n = 1'b1;
      run_a(32'h3C3C_5AA5, 1'b0, mw, cs_low, rises, done_cyc, busy1);
      check("a_post_rst_done_cycle", done_cyc, 132);
      check("a_post_rst_rx", rx_a, 32'h3C3C_5AA5);

      // B: only cs_n[2] low for 147 cycles, SCLK period 6, 24 rising edges.
      @(negedge clk);
      cs_sel_b = 2'd2; tx_b = 24'hC35A96; start_b = 1'b1; en_b = 1'b1;
      @(posedge clk);
      only2 = 0; other = 0; high_cnt = 0; rises = 0; r1 = 0; r2 = 0; done_cyc = 0; prev = 1'b0;
      for (int c = 1; c <= 400 && done_cyc == 0; c++) begin
         @(negedge clk);
         start_b = 1'b0;
         if (cs_n_b == 4'b1011) only2++;
         else if (cs_n_b != 4'b1111) other++;
         if (sclk_b) high_cnt++;
         if (sclk_b && !prev) begin
            rises++;
            if (rises == 1) r1 = c;
            if (rises == 2) r2 = c;
         end
         prev = sclk_b;
         if (done_b) done_cyc = c;
      end
      $display("b single: rx=%06h done_cyc=%0d rises=%0d", rx_b, done_cyc, rises);
      check("b_cs2_low", only2, 147);
      check("b_other_cs_low", other, 0);
      check("b_sclk_rises", rises, 24);
      check("b_first_rise", r1, 4);
      check("b_sclk_period", r2 - r1, 6);
      check("b_sclk_high_cycles", high_cnt, 72);
      check("b_done_cycle", done_cyc, 151);
      check("b_rx_word", rx_b, 24'hC35A96);

      // B: start held high; each transaction lasts 151 cycles including the done cycle.
      @(negedge clk);
      cs_sel_b = 2'd1; tx_b = 24'h00F00F; start_b = 1'b1;
      @(posedge clk);
      ndone = 0; nper = 0; min_gap = 1000; run_hi = 0; in_low = 1'b0; seen_low = 1'b0; last_done = 0;
      for (int c = 1; c <= 453; c++) begin
         @(negedge clk);
         if (c == 453) start_b = 1'b0;
         if (cs_n_b != 4'b1111) begin
            if (!in_low) begin
               nper++;
               if (seen_low && run_hi < min_gap) min_gap = run_hi;
            end
            in_low = 1'b1; seen_low = 1'b1; run_hi = 0;
         end else begin
            in_low = 1'b0;
            run_hi++;
         end
         if (done_b) begin
            ndone++;
            last_done = c;
         end
      end
      $display("b held: dones=%0d periods=%0d min_gap=%0d", ndone, nper, min_gap);
      check("b_held_dones", ndone, 3);
      check("b_held_periods", nper, 3);
      check("b_held_min_gap", min_gap, 4);
      check("b_held_last_done", last_done, 453);
      check("b_held_rx", rx_b, 24'h00F00F);

      // C: out-of-range select keeps every cs_n high but still clocks and completes.
      run_c(2'd3, 8'h9C, any_low, lo0, toggles, done_cyc);
      $display("c sel3: rx=%02h toggles=%0d done_cyc=%0d", rx_c, toggles, done_cyc);
      check("c_sel3_cs_low", any_low, 0);
      check("c_sel3_toggles", toggles, 16);
      check("c_sel3_done_cycle", done_cyc, 19);
      check("c_sel3_rx", rx_c, 8'h9C);
      run_c(2'd0, 8'h3E, any_low, lo0, toggles, done_cyc);
      $display("c sel0: rx=%02h toggles=%0d done_cyc=%0d", rx_c, toggles, done_cyc);
      check("c_sel0_cs0_low", lo0, 17);
      check("c_sel0_any_low", any_low, 17);
      check("c_sel0_rx", rx_c, 8'h3E);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
